// File: rtl/corePckg.sv
// Shared types, funct3 encodings and lane helpers for the load/store stage.
package corePckg;

    localparam int cXLEN  = 32;
    localparam int cRegAW = 5;

    localparam logic [2:0] eLB  = 3'b000;
    localparam logic [2:0] eLH  = 3'b001;
    localparam logic [2:0] eLW  = 3'b010;
    localparam logic [2:0] eLBU = 3'b100;
    localparam logic [2:0] eLHU = 3'b101;
    localparam logic [2:0] eSB  = 3'b000;
    localparam logic [2:0] eSH  = 3'b001;
    localparam logic [2:0] eSW  = 3'b010;

    typedef enum logic [1:0] {
        eLsuIdle,
        eLsuReq,
        eLsuResp
    } tLsuState;

    typedef struct packed {
        logic              read;
        logic              write;
        logic [2:0]        opType;
        logic [cXLEN-1:0]  addr;
        logic [cXLEN-1:0]  data;
        logic [cRegAW-1:0] rdAddr;
    } tMemOp;

    function automatic logic fLoadLegal(input logic [2:0] f3);
        return f3 inside {eLB, eLH, eLW, eLBU, eLHU};
    endfunction

    function automatic logic fStoreLegal(input logic [2:0] f3);
        return f3 inside {eSB, eSH, eSW};
    endfunction

    function automatic logic fMisaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    endfunction

    // Force the offending low address bits to zero for halfword/word accesses.
    function automatic logic [1:0] fAlignLo(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return {lo[1], 1'b0};
            2'b10:   return 2'b00;
            default: return lo;
        endcase
    endfunction

    function automatic logic [3:0] fByteEn(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lo;
            2'b01:   return 4'b0011 << lo;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [cXLEN-1:0] fStoreData(input logic [2:0] f3, input logic [cXLEN-1:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/load_data_align.sv
// Combinational load lane select: shifts the addressed byte/halfword down and
// sign- or zero-extends it according to funct3.
module load_data_align
    import corePckg::*;
(
    input  logic [2:0]       iFunct3,
    input  logic [1:0]       iAddrLo,
    input  logic [cXLEN-1:0] iRdata,
    output logic [cXLEN-1:0] oData
);

    logic [cXLEN-1:0] shifted;

    always_comb begin
        shifted = iRdata >> {iAddrLo, 3'b000};
        case (iFunct3)
            eLB:     oData = {{24{shifted[7]}}, shifted[7:0]};
            eLH:     oData = {{16{shifted[15]}}, shifted[15:0]};
            eLBU:    oData = {24'h0, shifted[7:0]};
            eLHU:    oData = {16'h0, shifted[15:0]};
            default: oData = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Load/store stage: req/gnt/rvalid data-memory master plus register writeback.
// Build option MISALIGN_TRAP_EN: misaligned halfword/word accesses trap instead of aligning down.
module mem_access_stage
    import corePckg::*;
(
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iMemRead,
    input  logic              iMemWrite,
    input  logic [2:0]        iMemFunct3,
    input  logic [cXLEN-1:0]  iMemAddr,
    input  logic [cXLEN-1:0]  iMemWdata,
    input  logic [cRegAW-1:0] iMemRdAddr,
    input  logic              iRegDv,
    input  logic [cRegAW-1:0] iRegAddr,
    input  logic [cXLEN-1:0]  iRegData,
    output logic              oStall,
    output logic              oDmemReq,
    output logic              oDmemWe,
    output logic [cXLEN-1:0]  oDmemAddr,
    output logic [3:0]        oDmemBe,
    output logic [cXLEN-1:0]  oDmemWdata,
    input  logic              iDmemGnt,
    input  logic              iDmemRvalid,
    input  logic [cXLEN-1:0]  iDmemRdata,
    output logic              oWbDv,
    output logic [cRegAW-1:0] oWbAddr,
    output logic [cXLEN-1:0]  oWbData,
    output logic              oMisalign,
    output logic [cXLEN-1:0]  oBadAddr
);

    tLsuState          state_q, state_d;
    tMemOp             op;
    logic              mem_seen, legal, take;
    logic [1:0]        lo_aligned;

    logic              req_q, req_d, we_q, we_d;
    logic [cXLEN-1:0]  addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [cRegAW-1:0] rd_q, rd_d;
    logic              wb_dv_q, wb_dv_d;
    logic [cRegAW-1:0] wb_addr_q, wb_addr_d;
    logic [cXLEN-1:0]  wb_data_q, wb_data_d;
    logic [cXLEN-1:0]  load_data;

    always_comb begin
        op.read   = iMemRead;
        op.write  = iMemWrite & ~iMemRead;
        op.opType = iMemFunct3;
        op.addr   = iMemAddr;
        op.data   = iMemWdata;
        op.rdAddr = iMemRdAddr;
        mem_seen   = iMemRead | iMemWrite;
        legal      = op.read ? fLoadLegal(op.opType) : fStoreLegal(op.opType);
        lo_aligned = fAlignLo(op.opType, op.addr[1:0]);
    end

`ifdef MISALIGN_TRAP_EN
    logic             misalign, trap_d, trap_q;
    logic [cXLEN-1:0] bad_addr_q;

    assign misalign = fMisaligned(op.opType, op.addr[1:0]);
    assign take     = legal & ~misalign;
    assign trap_d   = (state_q == eLsuIdle) & mem_seen & legal & misalign;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            trap_q     <= 1'b0;
            bad_addr_q <= '0;
        end else begin
            trap_q     <= trap_d;
            bad_addr_q <= trap_d ? iMemAddr : '0;
        end
    end

    assign oMisalign = trap_q;
    assign oBadAddr  = bad_addr_q;
`else
    assign take      = legal;
    assign oMisalign = 1'b0;
    assign oBadAddr  = '0;
`endif

    load_data_align u_align (
        .iFunct3 (funct3_q),
        .iAddrLo (addr_lo_q),
        .iRdata  (iDmemRdata),
        .oData   (load_data)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        rd_d      = rd_q;
        wb_dv_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        case (state_q)
            eLsuIdle: begin
                // A memory op, even an illegal one, always shadows a same-cycle ALU result.
                if (mem_seen) begin
                    if (take) begin
                        state_d   = eLsuReq;
                        req_d     = 1'b1;
                        we_d      = op.write;
                        addr_d    = {op.addr[cXLEN-1:2], 2'b00};
                        be_d      = fByteEn(op.opType, lo_aligned);
                        wdata_d   = op.write ? fStoreData(op.opType, op.data) : '0;
                        funct3_d  = op.opType;
                        addr_lo_d = lo_aligned;
                        rd_d      = op.rdAddr;
                    end
                end else if (iRegDv && (iRegAddr != '0)) begin
                    wb_dv_d   = 1'b1;
                    wb_addr_d = iRegAddr;
                    wb_data_d = iRegData;
                end
            end
            eLsuReq: begin
                if (iDmemGnt) begin
                    state_d = we_q ? eLsuIdle : eLsuResp;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    be_d    = '0;
                    wdata_d = '0;
                end
            end
            eLsuResp: begin
                if (iDmemRvalid) begin
                    state_d = eLsuIdle;
                    if (rd_q != '0) begin
                        wb_dv_d   = 1'b1;
                        wb_addr_d = rd_q;
                        wb_data_d = load_data;
                    end
                end
            end
            default: state_d = eLsuIdle;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q   <= eLsuIdle;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            rd_q      <= '0;
            wb_dv_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
            rd_q      <= rd_d;
            wb_dv_q   <= wb_dv_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign oStall     = (state_q != eLsuIdle);
    assign oDmemReq   = req_q;
    assign oDmemWe    = we_q;
    assign oDmemAddr  = addr_q;
    assign oDmemBe    = be_q;
    assign oDmemWdata = wdata_q;
    assign oWbDv      = wb_dv_q;
    assign oWbAddr    = wb_addr_q;
    assign oWbData    = wb_data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; honours MISALIGN_TRAP_EN for the misaligned-word case.
module tb_mem_access_stage;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iMemRead, iMemWrite;
    logic [2:0]  iMemFunct3;
    logic [31:0] iMemAddr, iMemWdata;
    logic [4:0]  iMemRdAddr;
    logic        iRegDv;
    logic [4:0]  iRegAddr;
    logic [31:0] iRegData;
    logic        oStall, oDmemReq, oDmemWe;
    logic [31:0] oDmemAddr, oDmemWdata;
    logic [3:0]  oDmemBe;
    logic        iDmemGnt, iDmemRvalid;
    logic [31:0] iDmemRdata;
    logic        oWbDv;
    logic [4:0]  oWbAddr;
    logic [31:0] oWbData;
    logic        oMisalign;
    logic [31:0] oBadAddr;

    int checks = 0;
    int errors = 0;

    always #5 iClk = ~iClk;

    mem_access_stage dut (
        .iClk(iClk), .iRst(iRst),
        .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iMemFunct3(iMemFunct3),
        .iMemAddr(iMemAddr), .iMemWdata(iMemWdata), .iMemRdAddr(iMemRdAddr),
        .iRegDv(iRegDv), .iRegAddr(iRegAddr), .iRegData(iRegData),
        .oStall(oStall), .oDmemReq(oDmemReq), .oDmemWe(oDmemWe),
        .oDmemAddr(oDmemAddr), .oDmemBe(oDmemBe), .oDmemWdata(oDmemWdata),
        .iDmemGnt(iDmemGnt), .iDmemRvalid(iDmemRvalid), .iDmemRdata(iDmemRdata),
        .oWbDv(oWbDv), .oWbAddr(oWbAddr), .oWbData(oWbData),
        .oMisalign(oMisalign), .oBadAddr(oBadAddr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic clear_inputs();
        iMemRead   = 1'b0;
        iMemWrite  = 1'b0;
        iMemFunct3 = 3'b000;
        iMemAddr   = '0;
        iMemWdata  = '0;
        iMemRdAddr = '0;
        iRegDv     = 1'b0;
        iRegAddr   = '0;
        iRegData   = '0;
    endtask

    task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d, input int gnt_wait,
                             input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        int stall_cycles;
        iMemWrite = 1'b1; iMemFunct3 = f3; iMemAddr = a; iMemWdata = d;
        tick();
        clear_inputs();
        check({tag, ".req"},   {31'h0, oDmemReq}, 32'h1);
        check({tag, ".we"},    {31'h0, oDmemWe}, 32'h1);
        check({tag, ".addr"},  oDmemAddr, {a[31:2], 2'b00});
        check({tag, ".be"},    {28'h0, oDmemBe}, {28'h0, exp_be});
        check({tag, ".wdata"}, oDmemWdata, exp_wdata);
        stall_cycles = 0;
        for (int i = 0; i <= gnt_wait; i++) begin
            if (oStall) stall_cycles++;
            iDmemGnt = (i == gnt_wait);
            tick();
        end
        iDmemGnt = 1'b0;
        check({tag, ".stall_cycles"}, stall_cycles, gnt_wait + 1);
        check({tag, ".req_after"}, {30'h0, oDmemReq, oStall}, 32'h0);
        check({tag, ".no_wb"}, {31'h0, oWbDv}, 32'h0);
    endtask

    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [4:0] rd, input logic [31:0] rdata, input logic both,
                            input logic [3:0] exp_be, input logic exp_dv, input logic [31:0] exp_data);
        iMemRead = 1'b1; iMemWrite = both; iMemFunct3 = f3; iMemAddr = a; iMemRdAddr = rd;
        iMemWdata = 32'h5A5A5A5A;
        tick();
        clear_inputs();
        check({tag, ".req"},  {30'h0, oDmemReq, oDmemWe}, 32'h2);
        check({tag, ".addr"}, oDmemAddr, {a[31:2], 2'b00});
        check({tag, ".be"},   {28'h0, oDmemBe}, {28'h0, exp_be});
        check({tag, ".mis"},  {31'h0, oMisalign}, 32'h0);
        iDmemGnt = 1'b1;
        tick();
        iDmemGnt = 1'b0;
        check({tag, ".resp"}, {30'h0, oDmemReq, oStall}, 32'h1);
        iDmemRvalid = 1'b1; iDmemRdata = rdata;
        tick();
        iDmemRvalid = 1'b0; iDmemRdata = '0;
        check({tag, ".wbdv"}, {31'h0, oWbDv}, {31'h0, exp_dv});
        if (exp_dv) begin
            check({tag, ".wbaddr"}, {27'h0, oWbAddr}, {27'h0, rd});
            check({tag, ".wbdata"}, oWbData, exp_data);
        end
        check({tag, ".stall_end"}, {31'h0, oStall}, 32'h0);
    endtask

    initial begin
        clear_inputs();
        iDmemGnt = 1'b0; iDmemRvalid = 1'b0; iDmemRdata = '0;
        iRst = 1'b0;
        repeat (2) @(posedge iClk);
        #2;
        check("reset.bus",  {oDmemReq, oDmemWe, oDmemBe, oStall}, 32'h0);
        check("reset.addr", oDmemAddr | oDmemWdata, 32'h0);
        check("reset.wb",   {oWbDv, oWbAddr, oMisalign}, 32'h0);
        check("reset.data", oWbData | oBadAddr, 32'h0);
        iRst = 1'b1;
        tick();

        run_store("sw",  3'b010, 32'h100, 32'hDEADBEEF, 2, 4'b1111, 32'hDEADBEEF);
        run_store("sb",  3'b000, 32'h103, 32'h000000A5, 0, 4'b1000, 32'hA5A5A5A5);
        run_store("sh",  3'b001, 32'h102, 32'h0000BEEF, 1, 4'b1100, 32'hBEEFBEEF);
        run_load("lb",   3'b000, 32'h202, 5'd5, 32'h12F45678, 1'b0, 4'b0100, 1'b1, 32'hFFFFFFF4);
        run_load("lbu",  3'b100, 32'h202, 5'd5, 32'h12F45678, 1'b1, 4'b0100, 1'b1, 32'h000000F4);
        run_load("lh",   3'b001, 32'h202, 5'd6, 32'h80001234, 1'b0, 4'b1100, 1'b1, 32'hFFFF8000);
        run_load("lhu",  3'b101, 32'h200, 5'd8, 32'h80001234, 1'b0, 4'b0011, 1'b1, 32'h00001234);
        run_load("lh_x0", 3'b001, 32'h202, 5'd0, 32'h80001234, 1'b0, 4'b1100, 1'b0, 32'h0);

        // ALU passthrough, 1-cycle latency, single pulse
        iRegDv = 1'b1; iRegAddr = 5'd7; iRegData = 32'h55;
        tick();
        clear_inputs();
        check("reg.wbdv",   {31'h0, oWbDv}, 32'h1);
        check("reg.wbaddr", {27'h0, oWbAddr}, 32'd7);
        check("reg.wbdata", oWbData, 32'h55);
        tick();
        check("reg.pulse",  {31'h0, oWbDv}, 32'h0);

        // memory op shadows a simultaneous ALU result even when illegal
        iMemRead = 1'b1; iMemFunct3 = 3'b011; iMemAddr = 32'h400; iMemRdAddr = 5'd4;
        iRegDv = 1'b1; iRegAddr = 5'd9; iRegData = 32'h77;
        tick();
        clear_inputs();
        check("illegal_ld", {29'h0, oDmemReq, oStall, oWbDv}, 32'h0);
        iMemWrite = 1'b1; iMemFunct3 = 3'b100; iMemAddr = 32'h404;
        tick();
        clear_inputs();
        check("illegal_st", {29'h0, oDmemReq, oStall, oWbDv}, 32'h0);

        // reset in RESP drops the load
        iMemRead = 1'b1; iMemFunct3 = 3'b010; iMemAddr = 32'h300; iMemRdAddr = 5'd3;
        tick();
        clear_inputs();
        iDmemGnt = 1'b1;
        tick();
        iDmemGnt = 1'b0;
        check("rst_mid.in_resp", {31'h0, oStall}, 32'h1);
        #2 iRst = 1'b0;
        #1;
        check("rst_mid.outs", {oStall, oDmemReq, oDmemWe, oDmemBe, oWbDv}, 32'h0);
        #1 iRst = 1'b1;
        iDmemRvalid = 1'b1; iDmemRdata = 32'h11111111;
        tick();
        iDmemRvalid = 1'b0;
        check("rst_mid.no_wb", {30'h0, oWbDv, oStall}, 32'h0);

`ifdef MISALIGN_TRAP_EN
        iMemRead = 1'b1; iMemFunct3 = 3'b010; iMemAddr = 32'h101; iMemRdAddr = 5'd9;
        tick();
        clear_inputs();
        check("lw_mis.pulse", {31'h0, oMisalign}, 32'h1);
        check("lw_mis.bad",   oBadAddr, 32'h101);
        check("lw_mis.noreq", {29'h0, oDmemReq, oStall, oWbDv}, 32'h0);
        tick();
        check("lw_mis.end",   {30'h0, oMisalign, oWbDv}, 32'h0);
`else
        run_load("lw_mis", 3'b010, 32'h101, 5'd9, 32'hCAFEF00D, 1'b0, 4'b1111, 1'b1, 32'hCAFEF00D);
        run_load("lhu_mis", 3'b101, 32'h203, 5'd10, 32'hABCD1234, 1'b0, 4'b1100, 1'b1, 32'h0000ABCD);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
